// File: rtl/pt_streamer.sv
// ---------------------------------------------------------------------------
// pt_streamer
//   Downstream consumer of the parallel-crack stage. When start is accepted it
//   latches the discovered 24-bit key and reads a length-prefixed plaintext
//   from pt_mem (address 0 holds the length L, addresses 1..L hold the
//   message). It then emits the key (3 bytes, MSB first, when EMIT_KEY=1)
//   followed by the L message bytes on a valid/ready byte stream.
//
// Parameters
//   EMIT_KEY   1 = prefix the stream with key[23:16], key[15:8], key[7:0]
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      start request, honoured only in IDLE or DONE
//   key_in     discovered key, latched in the cycle start is accepted
//   pt_addr    pt_mem read address (registered)
//   pt_rddata  pt_mem read data, valid the cycle after pt_addr is presented
//   out_data   stream byte
//   out_valid  out_data is valid
//   out_ready  downstream accepts the byte on out_valid && out_ready
//   out_last   marks the final byte of the stream
//   busy       high from accepted start until DONE
//   done       high in DONE until the next accepted start or reset
// ---------------------------------------------------------------------------
module pt_streamer #(
  parameter bit EMIT_KEY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] key_in,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, RD_LEN, LAT_LEN, KEY, RD_BYTE, LAT_BYTE, SEND, DONE
  } state_t;

  state_t      state;
  logic [23:0] key_q;
  logic [7:0]  len_q;
  // 9 bits so that idx == L still compares correctly when L = 255.
  logic [8:0]  idx;
  logic [1:0]  kidx;
  logic        accept;

  assign accept = out_valid && out_ready;

  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] i);
    case (i)
      2'd0:    key_byte = k[23:16];
      2'd1:    key_byte = k[15:8];
      default: key_byte = k[7:0];
    endcase
  endfunction

  // NOTE: all state and outputs live in one clocked block using non-blocking
  // assignments, so every right-hand side sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: no storage array here, so every register gets a reset value;
      // pt_mem itself is external and is never reset.
      state     <= IDLE;
      key_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      kidx      <= '0;
      pt_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_q   <= key_in;
            done    <= 1'b0;
            busy    <= 1'b1;
            pt_addr <= 8'd0;
            state   <= RD_LEN;
          end
        end

        // Address 0 is presented during RD_LEN; its data arrives in LAT_LEN.
        RD_LEN: state <= LAT_LEN;

        LAT_LEN: begin
          len_q <= pt_rddata;
          idx   <= 9'd1;
          kidx  <= 2'd0;
          if (EMIT_KEY) begin
            out_data  <= key_q[23:16];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= KEY;
          end else if (pt_rddata != 8'd0) begin
            pt_addr <= 8'd1;
            state   <= RD_BYTE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        // Key bytes are loaded back to back so an always-ready sink takes
        // one per cycle.
        KEY: begin
          if (accept) begin
            if (kidx == 2'd2) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (len_q != 8'd0) begin
                pt_addr <= 8'd1;
                state   <= RD_BYTE;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              kidx     <= kidx + 2'd1;
              out_data <= key_byte(key_q, kidx + 2'd1);
              // With an empty message the last key byte closes the stream.
              out_last <= (kidx == 2'd1) && (len_q == 8'd0);
            end
          end
        end

        // pt_addr was loaded on entry, so the byte is readable in LAT_BYTE.
        RD_BYTE: state <= LAT_BYTE;

        LAT_BYTE: begin
          out_data  <= pt_rddata;
          out_valid <= 1'b1;
          out_last  <= (idx == {1'b0, len_q});
          state     <= SEND;
        end

        SEND: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == {1'b0, len_q}) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx     <= idx + 9'd1;
              pt_addr <= idx[7:0] + 8'd1;
              state   <= RD_BYTE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          key_q     <= '0;
          len_q     <= '0;
          idx       <= '0;
          kidx      <= '0;
          pt_addr   <= '0;
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_streamer.sv
// ---------------------------------------------------------------------------
// tb_pt_streamer
//   Directed bench for pt_streamer. Two instances share one plaintext memory
//   image: dut1 with EMIT_KEY=1 and dut0 with EMIT_KEY=0. Each has its own
//   synchronous-read port onto the memory. A monitor records accepted bytes
//   and checks that a stalled byte is held unchanged.
// ---------------------------------------------------------------------------
module tb_pt_streamer;

  logic        clk;
  logic        rst;
  logic        start1, start0;
  logic [23:0] key1, key0;
  logic [7:0]  a1, a0, rd1, rd0, d1, d0;
  logic        v1, v0, rdy1, rdy0, l1, l0;
  logic        busy1, busy0, done1, done0;

  logic [7:0]  mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  pt_streamer #(.EMIT_KEY(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key1),
    .pt_addr(a1), .pt_rddata(rd1),
    .out_data(d1), .out_valid(v1), .out_ready(rdy1), .out_last(l1),
    .busy(busy1), .done(done1)
  );

  pt_streamer #(.EMIT_KEY(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .key_in(key0),
    .pt_addr(a0), .pt_rddata(rd0),
    .out_data(d0), .out_valid(v0), .out_ready(rdy0), .out_last(l0),
    .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data is valid the cycle after the address.
  always @(posedge clk) begin
    rd1 <= mem[a1];
    rd0 <= mem[a0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         zero0 = 0;
  logic [8:0] q1[$], q0[$];
  int         t1[$];
  logic       pv1 = 1'b0, pr1 = 1'b0, pv0 = 1'b0, pr0 = 1'b0;
  logic [8:0] pd1 = '0, pd0 = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pv1 = 1'b0;
      pv0 = 1'b0;
    end else begin
      if (pv1 && !pr1) begin
        check("hold_valid1", v1, 1);
        check("hold_data1", {l1, d1}, pd1);
      end
      if (pv0 && !pr0) begin
        check("hold_valid0", v0, 1);
        check("hold_data0", {l0, d0}, pd0);
      end
      if (v1 && rdy1) begin
        q1.push_back({l1, d1});
        t1.push_back(cyc);
      end
      if (v0 && rdy0) q0.push_back({l0, d0});
      if (busy0 && a0 == 8'd0) zero0++;
      pv1 = v1; pr1 = rdy1; pd1 = {l1, d1};
      pv0 = v0; pr0 = rdy0; pd0 = {l0, d0};
    end
  end

  // ---------------- helpers ----------------
  task automatic load_abc();
    mem[0] = 8'd3;
    mem[1] = 8'h61;
    mem[2] = 8'h62;
    mem[3] = 8'h63;
  endtask

  task automatic do_start(input bit sel, input logic [23:0] k);
    if (sel) begin start1 = 1'b1; key1 = k; end
    else     begin start0 = 1'b1; key0 = k; end
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  // mode 0: ready held as is; mode 1: ready high one cycle in three.
  task automatic run_done(input bit sel, input int mode, input int budget);
    int c = 0;
    while (c < budget && !(sel ? done1 : done0)) begin
      if (mode == 1) begin
        if (sel) rdy1 = (c % 3 == 2);
        else     rdy0 = (c % 3 == 2);
      end
      @(posedge clk); #1;
      c++;
    end
    check(sel ? "done1" : "done0", sel ? done1 : done0, 1);
    check(sel ? "busy1_end" : "busy0_end", sel ? busy1 : busy0, 0);
  endtask

  task automatic wait_valid0(input int budget);
    int c = 0;
    while (c < budget && !v0) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_valid0", v0, 1);
  endtask

  task automatic check_q(input string tag, input bit sel, input logic [8:0] exp[$]);
    logic [8:0] got[$];
    got = sel ? q1 : q0;
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] e[$];

    rst = 1'b1;
    start1 = 1'b0; start0 = 1'b0;
    key1 = '0; key0 = '0;
    rdy1 = 1'b0; rdy0 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state, with start asserted to show reset wins.
    start1 = 1'b1;
    start0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid1", v1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_addr1", a1, 0);
    check("rst_data1", d1, 0);
    check("rst_last1", l1, 0);
    check("rst_valid0", v0, 0);
    check("rst_busy0", busy0, 0);
    start1 = 1'b0;
    start0 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: key + "abc", always ready.
    load_abc();
    q1.delete(); t1.delete();
    rdy1 = 1'b1;
    do_start(1, 24'h1E4600);
    check("t1_busy", busy1, 1);
    run_done(1, 0, 200);
    e = '{9'h01E, 9'h046, 9'h000, 9'h061, 9'h062, 9'h163};
    check_q("t1", 1, e);
    if (t1.size() == 6) begin
      check("t1_gap_k1", t1[1] - t1[0], 1);
      check("t1_gap_k2", t1[2] - t1[1], 1);
      check("t1_gap_m1", t1[3] - t1[2], 3);
      check("t1_gap_m2", t1[4] - t1[3], 3);
      check("t1_gap_m3", t1[5] - t1[4], 3);
    end

    // 2: same, ready toggling 1-of-3.
    q1.delete(); t1.delete();
    rdy1 = 1'b0;
    do_start(1, 24'h1E4600);
    check("t2_done_clr", done1, 0);
    run_done(1, 1, 400);
    check_q("t2", 1, e);
    rdy1 = 1'b1;

    // Empty message with key: last flag moves onto key[7:0].
    mem[0] = 8'd0;
    q1.delete(); t1.delete();
    do_start(1, 24'hC0FFEE);
    run_done(1, 0, 100);
    e = '{9'h0C0, 9'h0FF, 9'h1EE};
    check_q("k_l0", 1, e);

    // 3: EMIT_KEY=0, L=0 -> no bytes, done exactly 3 cycles after start.
    q0.delete();
    rdy0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("t3_busy_c1", busy0, 1);
    check("t3_done_c1", done0, 0);
    @(posedge clk); #1;
    check("t3_done_c2", done0, 0);
    @(posedge clk); #1;
    check("t3_done_c3", done0, 1);
    check("t3_busy_c3", busy0, 0);
    check("t3_nobytes", q0.size(), 0);

    // 4: L=255, byte value = address.
    mem[0] = 8'd255;
    for (int i = 1; i < 256; i++) mem[i] = 8'(i);
    q0.delete();
    zero0 = 0;
    do_start(0, 24'h0);
    run_done(0, 0, 2000);
    e = {};
    for (int i = 1; i < 256; i++) e.push_back({i == 255, 8'(i)});
    check_q("t4", 0, e);
    check("t4_addr0_cycles", zero0, 2);
    check("t4_final_addr", a0, 8'hFF);

    // 5: reset while byte 2 is waiting in SEND.
    load_abc();
    q0.delete();
    rdy0 = 1'b0;
    do_start(0, 24'h0);
    wait_valid0(20);
    check("t5_b1", {l0, d0}, 9'h061);
    rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    wait_valid0(20);
    check("t5_b2", {l0, d0}, 9'h062);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_valid", v0, 0);
    check("t5_busy", busy0, 0);
    check("t5_addr", a0, 0);
    check("t5_done", done0, 0);
    q0.delete();
    rdy0 = 1'b1;
    do_start(0, 24'h0);
    run_done(0, 0, 100);
    e = '{9'h061, 9'h062, 9'h163};
    check_q("t5_replay", 0, e);

    // 6: start mid-stream is ignored; a later start carries the new key.
    q1.delete(); t1.delete();
    rdy1 = 1'b1;
    do_start(1, 24'h123456);
    repeat (5) begin
      @(posedge clk); #1;
    end
    start1 = 1'b1;
    key1 = 24'hABCDEF;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("t6_busy_mid", busy1, 1);
    check("t6_done_mid", done1, 0);
    run_done(1, 0, 200);
    e = '{9'h012, 9'h034, 9'h056, 9'h061, 9'h062, 9'h163};
    check_q("t6_first", 1, e);
    q1.delete(); t1.delete();
    do_start(1, 24'hABCDEF);
    key1 = 24'h999999;
    run_done(1, 0, 200);
    e = '{9'h0AB, 9'h0CD, 9'h0EF, 9'h061, 9'h062, 9'h163};
    check_q("t6_second", 1, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
